// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Imported by the sequencer top and its debounce sub-block.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    SETP    = 2'd3
  } state_t;

  localparam int DEF_N_STAGES = 3;
  localparam int DEF_HOLD_CYC = 16;
  localparam int DEF_GAP_CYC  = 4;
  localparam int DEF_SET_CYC  = 2;
  localparam int DEF_DEB_CYC  = 8;

  function automatic int cnt_w(
    input int h,
    input int g,
    input int s,
    input int d
  );
    int m;
    m = h;
    if (g > m) m = g;
    if (s > m) m = s;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer.
// The output flips once the synced input has disagreed for DEB_CYC cycles.
module sync_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC,
  parameter int CW      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic deb
);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      deb <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 != deb) begin
        if (cnt >= CW'(DEB_CYC - 1)) begin
          deb <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release and set-pulse generator for one clock domain.
// Holds all stages in reset, releases them in order, then serves set requests.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_STAGES = DEF_N_STAGES,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int SET_CYC  = DEF_SET_CYC,
  parameter int DEB_CYC  = DEF_DEB_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_rst,
  input  logic                req_set,
  output logic [N_STAGES-1:0] rstn_out,
  output logic                set_n_out,
  output logic                ready,
  output logic                busy
);

  localparam int CW = cnt_w(HOLD_CYC, GAP_CYC, SET_CYC, DEB_CYC);
  localparam int IW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [CW-1:0] CMAX = '1;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nx;

  logic [N_STAGES-1:0] rstn_nx;
  logic                set_n_nx;
  logic                ready_nx;
  logic                busy_nx;

  logic deb;
  logic ss1;
  logic ss2;
  logic ss2_q;
  logic set_rise;

  sync_debounce #(
    .DEB_CYC (DEB_CYC),
    .CW      (CW)
  ) u_deb (
    .clk (clk),
    .rst (rst),
    .din (req_rst),
    .deb (deb)
  );

  // Set request: synchronize, then register a one-cycle rise pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      ss1      <= 1'b0;
      ss2      <= 1'b0;
      ss2_q    <= 1'b0;
      set_rise <= 1'b0;
    end else begin
      ss1      <= req_set;
      ss2      <= ss1;
      ss2_q    <= ss2;
      set_rise <= ss2 & ~ss2_q;
    end
  end

  function automatic logic [CW-1:0] inc(input logic [CW-1:0] c);
    return (c == CMAX) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      cnt       <= '0;
      idx       <= '0;
      rstn_out  <= '0;
      set_n_out <= 1'b1;
      ready     <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      rstn_out  <= rstn_nx;
      set_n_out <= set_n_nx;
      ready     <= ready_nx;
      busy      <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    rstn_nx  = rstn_out;
    set_n_nx = set_n_out;
    ready_nx = ready;
    busy_nx  = busy;
    // A debounced request outside HOLD overrides any progress
    if (deb && state != HOLD) begin
      state_nx = HOLD;
      cnt_nx   = '0;
      idx_nx   = '0;
      rstn_nx  = '0;
      set_n_nx = 1'b1;
      ready_nx = 1'b0;
      busy_nx  = 1'b1;
    end else begin
      unique case (state)
        HOLD: begin
          rstn_nx  = '0;
          set_n_nx = 1'b1;
          ready_nx = 1'b0;
          busy_nx  = 1'b1;
          if (deb) begin
            cnt_nx = '0;
          end else if (cnt >= CW'(HOLD_CYC - 1)) begin
            cnt_nx  = '0;
            rstn_nx = N_STAGES'(1);
            if (N_STAGES == 1) begin
              state_nx = RUN;
              ready_nx = 1'b1;
              busy_nx  = 1'b0;
            end else begin
              state_nx = RELEASE;
              idx_nx   = IW'(1);
            end
          end else begin
            cnt_nx = inc(cnt);
          end
        end
        RELEASE: begin
          if (cnt >= CW'(GAP_CYC - 1)) begin
            cnt_nx  = '0;
            rstn_nx = rstn_out | (N_STAGES'(1) << idx);
            if (idx == IW'(N_STAGES - 1)) begin
              state_nx = RUN;
              ready_nx = 1'b1;
              busy_nx  = 1'b0;
            end else begin
              idx_nx = idx + 1'b1;
            end
          end else begin
            cnt_nx = inc(cnt);
          end
        end
        RUN: begin
          rstn_nx = '1;
          if (set_rise) begin
            state_nx = SETP;
            cnt_nx   = '0;
            set_n_nx = 1'b0;
            ready_nx = 1'b0;
          end
        end
        SETP: begin
          if (cnt >= CW'(SET_CYC - 1)) begin
            state_nx = RUN;
            cnt_nx   = '0;
            set_n_nx = 1'b1;
            ready_nx = 1'b1;
          end else begin
            cnt_nx = inc(cnt);
          end
        end
        default: begin
          state_nx = HOLD;
          cnt_nx   = '0;
          idx_nx   = '0;
          rstn_nx  = '0;
          set_n_nx = 1'b1;
          ready_nx = 1'b0;
          busy_nx  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_rst;
  logic       req_set;
  logic [2:0] rstn_out;
  logic       set_n_out;
  logic       ready;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_rst   (req_rst),
    .req_set   (req_set),
    .rstn_out  (rstn_out),
    .set_n_out (set_n_out),
    .ready     (ready),
    .busy      (busy)
  );

  typedef struct {
    int         n;
    logic       r;
    logic       rr;
    logic       rs;
    logic [2:0] rstn;
    logic       sn;
    logic       rdy;
    logic       bsy;
    string      nm;
  } vec_t;

  vec_t tbl[9];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [2:0] er,
                     input logic es, input logic erd, input logic eb);
    n_cmp++;
    if ({rstn_out, set_n_out, ready, busy} !== {er, es, erd, eb}) begin
      n_bad++;
      $display("FAIL %s: got rstn=%b set_n=%b ready=%b busy=%b want rstn=%b set_n=%b ready=%b busy=%b",
               nm, rstn_out, set_n_out, ready, busy, er, es, erd, eb);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    int lo_set;
    int lo_rdy;
    int hi_set;
    int not7;
    int waited;

    rst     = 1'b1;
    req_rst = 1'b0;
    req_set = 1'b0;

    tbl[0] = '{3,  1, 0, 0, 3'b000, 1, 0, 1, "reset"};
    tbl[1] = '{15, 0, 0, 0, 3'b000, 1, 0, 1, "hold15"};
    tbl[2] = '{1,  0, 0, 0, 3'b001, 1, 0, 1, "rel0"};
    tbl[3] = '{3,  0, 0, 0, 3'b001, 1, 0, 1, "gap0"};
    tbl[4] = '{1,  0, 0, 0, 3'b011, 1, 0, 1, "rel1"};
    tbl[5] = '{3,  0, 0, 0, 3'b011, 1, 0, 1, "gap1"};
    tbl[6] = '{1,  0, 0, 0, 3'b111, 1, 1, 0, "rel2"};
    tbl[7] = '{5,  0, 1, 0, 3'b111, 1, 1, 0, "glitch_in"};
    tbl[8] = '{20, 0, 0, 0, 3'b111, 1, 1, 0, "glitch_out"};

    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      rst     = tbl[i].r;
      req_rst = tbl[i].rr;
      req_set = tbl[i].rs;
      step(tbl[i].n);
      chk(tbl[i].nm, tbl[i].rstn, tbl[i].sn, tbl[i].rdy, tbl[i].bsy);
    end

    // Long request: assert at edge 11, hold while deb high, then 16/4/4
    req_rst = 1'b1;
    step(10);
    chk("req_e10", 3'b111, 1, 1, 0);
    step(1);
    chk("req_e11", 3'b000, 1, 0, 1);
    step(9);
    chk("req_held", 3'b000, 1, 0, 1);
    req_rst = 1'b0;
    step(25);
    chk("deb_hold25", 3'b000, 1, 0, 1);
    step(1);
    chk("deb_rel0", 3'b001, 1, 0, 1);
    step(4);
    chk("deb_rel1", 3'b011, 1, 0, 1);
    step(4);
    chk("deb_rel2", 3'b111, 1, 1, 0);

    // Held set request: exactly one pulse of two cycles
    req_set = 1'b1;
    lo_set = 0;
    lo_rdy = 0;
    not7 = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) req_set = 1'b0;
      step(1);
      if (!set_n_out) lo_set++;
      if (!ready) lo_rdy++;
      if (rstn_out != 3'b111) not7++;
    end
    chk_int("set_low_cycles", lo_set, 2);
    chk_int("set_ready_low", lo_rdy, 2);
    chk_int("set_rstn_kept", not7, 0);
    chk("set_done", 3'b111, 1, 1, 0);

    // Debounced request landing inside the set pulse
    req_rst = 1'b1;
    step(6);
    req_set = 1'b1;
    step(4);
    chk("setp_active", 3'b111, 0, 0, 0);
    step(1);
    chk("setp_abort", 3'b000, 1, 0, 1);
    req_rst = 1'b0;
    req_set = 1'b0;
    waited = 0;
    while (!ready && waited < 100) begin
      step(1);
      waited++;
    end
    chk("abort_recover", 3'b111, 1, 1, 0);

    // Sync reset mid-release restarts the full hold
    rst = 1'b1;
    step(1);
    chk("rst_run", 3'b000, 1, 0, 1);
    rst = 1'b0;
    step(16);
    chk("rst_rel0", 3'b001, 1, 0, 1);
    step(4);
    chk("rst_rel1", 3'b011, 1, 0, 1);
    rst = 1'b1;
    step(1);
    chk("rst_mid", 3'b000, 1, 0, 1);
    rst = 1'b0;
    step(15);
    chk("rst_hold15", 3'b000, 1, 0, 1);
    step(1);
    chk("rst_again0", 3'b001, 1, 0, 1);

    // Set rise during RELEASE is dropped, held level must not fire later
    req_set = 1'b1;
    hi_set = 0;
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (!set_n_out) hi_set++;
    end
    chk_int("rel_set_drop", hi_set, 0);
    chk("rel_set_end", 3'b111, 1, 1, 0);
    req_set = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
